// File: rtl/out_buf_pkg.sv
// Shared definitions for the output-buffer write arbiter and its round-robin picker.
// State encoding is fixed so the read-side arbiter can reuse it.
package out_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after last_grant, wrapping modulo NUM_REQ.
// Shared by the write- and read-side output buffer arbiters.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        // Scan starts one past the previous owner, so the previous owner is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/out_buf_write_arbiter.sv
// Round-robin arbiter sharing one output write buffer between NUM_REQ write controllers.
// Optional write timeout with sticky error state is enabled by defining WRITE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate and latch winner's word when any req is set
// GRANT | owner holds the buffer; write this cycle if buffer_ready
// WAIT  | owner stalled by buffer backpressure; write when buffer_ready rises
// ERROR | buffer stuck past TIMEOUT (WRITE_TIMEOUT_EN only); exits on rst
module out_buf_write_arbiter
    import out_buf_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      buffer_ready,
    output logic                      buffer_write_en,
    output logic [DATA_W-1:0]         buffer_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        stall,
    output logic                      busy,
    output logic                      err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("out_buf_write_arbiter: NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("out_buf_write_arbiter: TIMEOUT must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             write;
    logic [NUM_REQ-1:0] owner_oh;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef WRITE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Counter value 0..TIMEOUT-1 covers exactly TIMEOUT cycles spent in WAIT.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!buffer_ready) begin
            if (state == ST_GRANT) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        write     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (buffer_ready) begin
                    write     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (buffer_ready) begin
                    write     = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef WRITE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = ST_ERROR;
                end
`endif
            end
`ifdef WRITE_TIMEOUT_EN
            ST_ERROR: state_nxt = ST_ERROR;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            buffer_wdata <= '0;
        end else begin
            state <= state_nxt;
            // Word is captured at arbitration; later req_data changes are ignored.
            if (state == ST_IDLE && any_req) begin
                owner        <= winner;
                buffer_wdata <= req_data[int'(winner)*DATA_W +: DATA_W];
            end
            if (write) begin
                last_grant <= owner;
            end
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign buffer_write_en = write;
    assign grant           = (state != ST_IDLE) ? owner_oh : '0;
    assign ack             = write ? owner_oh : '0;
    assign stall           = req & ~ack;
    assign busy            = (state != ST_IDLE);

`ifdef WRITE_TIMEOUT_EN
    assign err = (state == ST_ERROR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/out_buf_write_arbiter.md
Name: out_buf_write_arbiter

Overview:
- Shares the single output write buffer between NUM_REQ processing-unit write controllers.
- Picks one requester by round-robin and latches that requester's data.
- Drives the buffer write strobe and holds the requester stalled while buffer_ready is low.
- Returns a one-cycle ack when the word is written; sits between the per-PE write controllers and the output buffer.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 16, width of one output word.
- TIMEOUT, 15, max cycles in WAIT before error; used only with WRITE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; level, held until ack.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- buffer_ready  input  1  output buffer can accept a word this cycle.
- buffer_write_en  output  1  write strobe to the buffer.
- buffer_wdata  output  DATA_W  latched word to the buffer.
- grant  output  NUM_REQ  one-hot owner; valid in GRANT and WAIT, else 0.
- ack  output  NUM_REQ  one-cycle pulse to the owner in the write cycle.
- stall  output  NUM_REQ  stall[i] = req[i] & ~ack[i].
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky timeout error; tied 0 when the feature is off.

Behaviour:
- Reset (async): state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first. grant, ack, buffer_write_en, busy and err are 0; buffer_wdata=0.
- States: IDLE, GRANT, WAIT, ERROR (ERROR exists only with WRITE_TIMEOUT_EN).
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ. Register owner=winner and buffer_wdata=req_data[winner]; go to GRANT next cycle.
- GRANT, buffer_ready=1 (write cycle): buffer_write_en=1 and ack[owner]=1, both combinational; last_grant<=owner; next state IDLE.
- GRANT, buffer_ready=0: go to WAIT and clear the wait counter.
- WAIT, buffer_ready=1: same write cycle as GRANT, then IDLE.
- WAIT, buffer_ready=0: stay in WAIT and increment the wait counter.
- Latency: req rises in IDLE at cycle N → write cycle at N+1 at the earliest. Peak throughput is one word every 2 cycles.
- Requester contract: hold req and data until ack; clear req on the edge that ends the ack cycle.
- Data is latched at arbitration; req_data changes after that are ignored.
- If req drops after the grant, the write still completes with the latched data. No abort path.
- Simultaneous requests resolve strictly round-robin; no requester waits more than NUM_REQ-1 grants.
- A request that arrives in GRANT or WAIT waits for IDLE with its stall bit high.
- Reset mid-write: any pending word is discarded and no ack is issued; requesters re-request.
- buffer_wdata holds its value between writes; it is meaningful only while buffer_write_en=1.

Optional Feature:
- Macro: WRITE_TIMEOUT_EN.
- With WRITE_TIMEOUT_EN: when the WAIT counter reaches TIMEOUT with buffer_ready still 0, go to ERROR. In ERROR: err=1 (sticky), busy=1, grant held, no write, no ack. Only rst exits ERROR.
- Without WRITE_TIMEOUT_EN: no counter and no ERROR state; WAIT lasts indefinitely; err tied 0.

Decomposition:
- Shared package out_buf_pkg:
  - state encoding (2-bit: IDLE=0, GRANT=1, WAIT=2, ERROR=3);
  - default localparams for NUM_REQ, DATA_W and TIMEOUT.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: req vector, last_grant index.
  - Outputs: winner index and any_req.
  - Reusable by the read-side arbiter.

Test Plan:
- Single request, ready always high: req=4'b0100, data 0x1234 → write at cycle 2 with wdata=0x1234, ack=4'b0100, last_grant=2.
- All requesters held high, ready always high: grant order 0,1,2,3,0; a write every 2nd cycle; stall high on the 3 waiting requesters.
- Backpressure: req[1] with ready=0 for 5 cycles → WAIT, stall[1]=1, no write_en. Ready rises → write in that same cycle, then IDLE.
- Data changes after grant: req_data[0] goes 0xAAAA→0x5555 one cycle after arbitration → the buffer receives 0xAAAA.
- Reset mid-WAIT: rst pulses while in WAIT → IDLE, all outputs 0, no ack; the next grant goes to requester 0.
- With WRITE_TIMEOUT_EN, TIMEOUT=15: ready held low → ERROR after 15 WAIT cycles, err=1 stays high; rst clears it.
